// File: rtl/rv32_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds opcodes, the FSM state type and the control-vector layout.
package rv32_ctrl_pkg;

    localparam logic [6:0] OpLw       = 7'b0000011;
    localparam logic [6:0] OpSw       = 7'b0100011;
    localparam logic [6:0] OpRType    = 7'b0110011;
    localparam logic [6:0] OpITypeAlu = 7'b0010011;
    localparam logic [6:0] OpBType    = 7'b1100011;
    localparam logic [6:0] OpJal      = 7'b1101111;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [6:0] OpLui      = 7'b0110111;
    localparam logic [6:0] OpAuipc    = 7'b0010111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
        StAluWb, StBranch, StJal, StJalr, StJalrWb, StUWb, StNopRet, StTrap
    } state_t;

    typedef enum logic [1:0] {SrcAPc = 2'b00, SrcAOldPc = 2'b01, SrcARs1 = 2'b10} alu_src_a_t;
    typedef enum logic [1:0] {SrcBRs2 = 2'b00, SrcBImm = 2'b01, SrcBFour = 2'b10} alu_src_b_t;
    typedef enum logic [1:0] {AluAdd = 2'b00, AluBranch = 2'b01, AluFunct = 2'b10} alu_op_t;
    typedef enum logic [1:0] {
        ResAluOut = 2'b00, ResMemData = 2'b01, ResAlu = 2'b10, ResImm = 2'b11
    } result_src_t;
    typedef enum logic [2:0] {
        ImmI = 3'b000, ImmS = 3'b001, ImmB = 3'b010, ImmJ = 3'b011, ImmU = 3'b100
    } imm_ctrl_t;

    typedef struct packed {
        logic        mem_req;
        logic        adr_src;
        logic        ir_write;
        logic        pc_write;
        logic        branch;
        logic        mem_write;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        result_src_t result_src;
        imm_ctrl_t   immediate_control;
        logic        u_imm_src;
        logic        reg_write;
        logic        instr_retired;
    } ctrl_t;

    // States that stall on mem_ready and therefore feed the watchdog.
    function automatic logic is_mem_wait_state(state_t s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit boundary: memory handshake, opcode input and datapath control outputs.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_fsm_if #(
    parameter int unsigned RETIRE_CNT_W = 32
);
    logic [6:0]              opcode;
    logic                    mem_ready;
    logic                    mem_req;
    logic                    adr_src;
    logic                    ir_write;
    logic                    pc_write;
    logic                    branch;
    logic                    mem_write;
    logic [1:0]              alu_src_a;
    logic [1:0]              alu_src_b;
    logic [1:0]              alu_op;
    logic [1:0]              result_src;
    logic [2:0]              immediate_control;
    logic                    u_imm_src;
    logic                    reg_write;
    logic                    illegal_instr;
    logic                    mem_timeout;
    logic                    instr_retired;
    logic [RETIRE_CNT_W-1:0] retire_count;

    modport master (
        input  opcode, mem_ready,
        output mem_req, adr_src, ir_write, pc_write, branch, mem_write, alu_src_a, alu_src_b,
               alu_op, result_src, immediate_control, u_imm_src, reg_write, illegal_instr,
               mem_timeout, instr_retired, retire_count
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, adr_src, ir_write, pc_write, branch, mem_write, alu_src_a, alu_src_b,
               alu_op, result_src, immediate_control, u_imm_src, reg_write, illegal_instr,
               mem_timeout, instr_retired, retire_count
    );

endinterface

// File: rtl/mc_output_decoder.sv
// Combinational state -> control-vector lookup for the multi-cycle control unit.
// Only FETCH (ir/pc write) and MEM_WRITE (retire) look at mem_ready.
module mc_output_decoder
    import rv32_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            StFetch: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SrcAPc;
                ctrl.alu_src_b  = SrcBFour;
                ctrl.alu_op     = AluAdd;
                ctrl.result_src = ResAlu;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            StDecode: begin
                // Branch target is precomputed here so BRANCH can finish in one cycle.
                ctrl.alu_src_a         = SrcAOldPc;
                ctrl.alu_src_b         = SrcBImm;
                ctrl.immediate_control = ImmB;
                ctrl.alu_op            = AluAdd;
            end
            StMemAdr: begin
                ctrl.alu_src_a         = SrcARs1;
                ctrl.alu_src_b         = SrcBImm;
                ctrl.immediate_control = (opcode == OpSw) ? ImmS : ImmI;
            end
            StMemRead: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            StMemWb: begin
                ctrl.result_src    = ResMemData;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            StMemWrite: begin
                ctrl.mem_req       = 1'b1;
                ctrl.mem_write     = 1'b1;
                ctrl.adr_src       = 1'b1;
                ctrl.instr_retired = mem_ready;
            end
            StExecR: begin
                ctrl.alu_src_a = SrcARs1;
                ctrl.alu_src_b = SrcBRs2;
                ctrl.alu_op    = AluFunct;
            end
            StExecI: begin
                ctrl.alu_src_a         = SrcARs1;
                ctrl.alu_src_b         = SrcBImm;
                ctrl.immediate_control = ImmI;
                ctrl.alu_op            = AluFunct;
            end
            StAluWb: begin
                ctrl.result_src    = ResAluOut;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a     = SrcARs1;
                ctrl.alu_src_b     = SrcBRs2;
                ctrl.alu_op        = AluBranch;
                ctrl.result_src    = ResAluOut;
                ctrl.branch        = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            StJal: begin
                ctrl.alu_src_a  = SrcAOldPc;
                ctrl.alu_src_b  = SrcBFour;
                ctrl.result_src = ResAluOut;
                ctrl.pc_write   = 1'b1;
            end
            StJalr: begin
                ctrl.alu_src_a         = SrcARs1;
                ctrl.alu_src_b         = SrcBImm;
                ctrl.immediate_control = ImmI;
                ctrl.result_src        = ResAlu;
                ctrl.pc_write          = 1'b1;
            end
            StJalrWb: begin
                ctrl.alu_src_a     = SrcAOldPc;
                ctrl.alu_src_b     = SrcBFour;
                ctrl.result_src    = ResAlu;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            StUWb: begin
                // opcode[5] separates LUI (1) from AUIPC (0).
                ctrl.immediate_control = ImmU;
                ctrl.u_imm_src         = ~opcode[5];
                ctrl.alu_src_a         = SrcAOldPc;
                ctrl.alu_src_b         = SrcBImm;
                ctrl.alu_op            = AluAdd;
                ctrl.result_src        = opcode[5] ? ResImm : ResAlu;
                ctrl.reg_write         = 1'b1;
                ctrl.instr_retired     = 1'b1;
            end
            StNopRet: begin
                ctrl.instr_retired = 1'b1;
            end
            StTrap: begin
                ctrl = '0;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: state register, next-state logic, memory watchdog
// and retired-instruction counter. Control outputs come from mc_output_decoder.
module multicycle_control_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter bit          TRAP_ON_ILLEGAL = 1'b1,
    parameter int unsigned MEM_TIMEOUT     = 0,
    parameter int unsigned RETIRE_CNT_W    = 32
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_control_fsm_if.master bus
);

    localparam int unsigned WdW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(MEM_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [WdW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [RETIRE_CNT_W-1:0] retire_cnt_q;
    logic                    mem_timeout_q;
    logic                    waiting, wd_fire;
    ctrl_t                   ctrl_raw, ctrl;

    mc_output_decoder u_output_decoder (
        .state     (state_q),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Outputs read all-zero while reset is held, whatever the state.
    assign ctrl = reset ? '0 : ctrl_raw;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpLw, OpSw:      state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpITypeAlu:      state_d = StExecI;
                    OpBType:         state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui, OpAuipc:  state_d = StUWb;
                    default:         state_d = TRAP_ON_ILLEGAL ? StTrap : StNopRet;
                endcase
            end
            StMemAdr:   state_d = (bus.opcode == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  if (bus.mem_ready) state_d = StMemWb;
            StMemWrite: if (bus.mem_ready) state_d = StFetch;
            StExecR, StExecI, StJal: state_d = StAluWb;
            StJalr:     state_d = StJalrWb;
            StMemWb, StAluWb, StBranch, StJalrWb, StUWb, StNopRet: state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase

        waiting = is_mem_wait_state(state_q) && !bus.mem_ready;
        wd_fire = (MEM_TIMEOUT != 0) && waiting && (wait_cnt_q == WdLast);
        if (wd_fire) state_d = StTrap;

        // Any state change clears the count; only consecutive stall cycles accumulate.
        if ((MEM_TIMEOUT != 0) && waiting && !wd_fire) wait_cnt_d = wait_cnt_q + 1'b1;
        else                                           wait_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            wait_cnt_q    <= '0;
            retire_cnt_q  <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (wd_fire)            mem_timeout_q <= 1'b1;
            if (ctrl.instr_retired) retire_cnt_q  <= retire_cnt_q + 1'b1;
        end
    end

    assign bus.mem_req           = ctrl.mem_req;
    assign bus.adr_src           = ctrl.adr_src;
    assign bus.ir_write          = ctrl.ir_write;
    assign bus.pc_write          = ctrl.pc_write;
    assign bus.branch            = ctrl.branch;
    assign bus.mem_write         = ctrl.mem_write;
    assign bus.alu_src_a         = ctrl.alu_src_a;
    assign bus.alu_src_b         = ctrl.alu_src_b;
    assign bus.alu_op            = ctrl.alu_op;
    assign bus.result_src        = ctrl.result_src;
    assign bus.immediate_control = ctrl.immediate_control;
    assign bus.u_imm_src         = ctrl.u_imm_src;
    assign bus.reg_write         = ctrl.reg_write;
    assign bus.instr_retired     = ctrl.instr_retired;
    assign bus.illegal_instr     = !reset && (state_q == StTrap) && !mem_timeout_q;
    assign bus.mem_timeout       = mem_timeout_q;
    assign bus.retire_count      = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: two control units (trap/watchdog/4-bit counter vs nop/no-watchdog/32-bit)
// driven with the same opcode/mem_ready/reset stream and checked cycle by cycle.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.RETIRE_CNT_W(4))  if_a ();
    multicycle_control_fsm_if #(.RETIRE_CNT_W(32)) if_b ();

    assign if_a.opcode    = opcode;
    assign if_a.mem_ready = mem_ready;
    assign if_b.opcode    = opcode;
    assign if_b.mem_ready = mem_ready;

    multicycle_control_fsm #(.TRAP_ON_ILLEGAL(1'b1), .MEM_TIMEOUT(8), .RETIRE_CNT_W(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.master)
    );

    multicycle_control_fsm #(.TRAP_ON_ILLEGAL(1'b0), .MEM_TIMEOUT(0), .RETIRE_CNT_W(32)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.master)
    );

    // Field order: mem_req adr_src ir_write pc_write branch mem_write src_a src_b alu_op
    //              result_src imm u_imm_src reg_write instr_retired
    function automatic logic [19:0] mk(input logic mr, ad, ir, pw, br, mw,
                                       input logic [1:0] sa, sb, op, rs,
                                       input logic [2:0] im, input logic u, rw, rt);
        return {mr, ad, ir, pw, br, mw, sa, sb, op, rs, im, u, rw, rt};
    endfunction

    function automatic logic [19:0] vec_a();
        return {if_a.mem_req, if_a.adr_src, if_a.ir_write, if_a.pc_write, if_a.branch,
                if_a.mem_write, if_a.alu_src_a, if_a.alu_src_b, if_a.alu_op, if_a.result_src,
                if_a.immediate_control, if_a.u_imm_src, if_a.reg_write, if_a.instr_retired};
    endfunction

    function automatic logic [19:0] vec_b();
        return {if_b.mem_req, if_b.adr_src, if_b.ir_write, if_b.pc_write, if_b.branch,
                if_b.mem_write, if_b.alu_src_a, if_b.alu_src_b, if_b.alu_op, if_b.result_src,
                if_b.immediate_control, if_b.u_imm_src, if_b.reg_write, if_b.instr_retired};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check both control vectors for the current cycle, then advance one clock.
    task automatic cyc(input logic [19:0] ea, input logic [19:0] eb, input string tag);
        #1;
        check({tag, ".a"}, 32'(vec_a()), 32'(ea));
        check({tag, ".b"}, 32'(vec_b()), 32'(eb));
        @(posedge clk);
        #2;
    endtask

    task automatic status(input string tag, input logic ill_a, ill_b, to_a, to_b,
                          input int rc_a, rc_b);
        check({tag, ".ill_a"}, 32'(if_a.illegal_instr), 32'(ill_a));
        check({tag, ".ill_b"}, 32'(if_b.illegal_instr), 32'(ill_b));
        check({tag, ".to_a"},  32'(if_a.mem_timeout),   32'(to_a));
        check({tag, ".to_b"},  32'(if_b.mem_timeout),   32'(to_b));
        check({tag, ".rc_a"},  32'(if_a.retire_count),  32'(rc_a));
        check({tag, ".rc_b"},  32'(if_b.retire_count),  32'(rc_b));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    logic [19:0] v_zero, v_f1, v_f0, v_dec, v_madr_lw, v_madr_sw, v_mrd, v_mwb, v_mwr_w;
    logic [19:0] v_mwr_r, v_exr, v_exi, v_awb, v_br, v_jal, v_jalr, v_jwb, v_lui, v_auipc;
    logic [19:0] v_nop;

    initial begin
        v_zero    = '0;
        v_f1      = mk(1, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 0);
        v_f0      = mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 0);
        v_dec     = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b010, 0, 0, 0);
        v_madr_lw = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        v_madr_sw = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b001, 0, 0, 0);
        v_mrd     = mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        v_mwb     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 1, 1);
        v_mwr_w   = mk(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        v_mwr_r   = mk(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1);
        v_exr     = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0);
        v_exi     = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000, 0, 0, 0);
        v_awb     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 1);
        v_br      = mk(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'b00, 3'b000, 0, 0, 1);
        v_jal     = mk(0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        v_jalr    = mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 3'b000, 0, 0, 0);
        v_jwb     = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b10, 3'b000, 0, 1, 1);
        v_lui     = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b11, 3'b100, 0, 1, 1);
        v_auipc   = mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b100, 1, 1, 1);
        v_nop     = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1);

        reset     = 1'b1;
        opcode    = 7'b0000011;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Reset held three cycles while stalled in MEM_READ.
        reset = 1'b0;
        mem_ready = 1'b1;
        cyc(v_f1, v_f1, "t1_fetch");
        cyc(v_dec, v_dec, "t1_dec");
        cyc(v_madr_lw, v_madr_lw, "t1_madr");
        mem_ready = 1'b0;
        cyc(v_mrd, v_mrd, "t1_mrd_wait");
        reset = 1'b1;
        repeat (3) begin
            status("t1_rst", 0, 0, 0, 0, 0, 0);
            cyc(v_zero, v_zero, "t1_rst");
        end
        reset = 1'b0;
        mem_ready = 1'b1;
        status("t1_post", 0, 0, 0, 0, 0, 0);

        // LW with zero-wait memory: five states, one retire pulse in the last.
        cyc(v_f1, v_f1, "t2_fetch");
        cyc(v_dec, v_dec, "t2_dec");
        cyc(v_madr_lw, v_madr_lw, "t2_madr");
        cyc(v_mrd, v_mrd, "t2_mrd");
        status("t2_pre_wb", 0, 0, 0, 0, 0, 0);
        cyc(v_mwb, v_mwb, "t2_mwb");
        status("t2_done", 0, 0, 0, 0, 1, 1);

        // SW with four stall cycles in MEM_WRITE.
        opcode = 7'b0100011;
        cyc(v_f1, v_f1, "t3_fetch");
        cyc(v_dec, v_dec, "t3_dec");
        cyc(v_madr_sw, v_madr_sw, "t3_madr");
        mem_ready = 1'b0;
        repeat (4) cyc(v_mwr_w, v_mwr_w, "t3_mwr_wait");
        mem_ready = 1'b1;
        cyc(v_mwr_r, v_mwr_r, "t3_mwr_ready");
        status("t3_done", 0, 0, 0, 0, 2, 2);

        // Illegal opcode: dut_a traps, dut_b retires a NOP.
        opcode = 7'b1111111;
        cyc(v_f1, v_f1, "t4_fetch");
        cyc(v_dec, v_dec, "t4_dec");
        status("t4_c3", 1, 0, 0, 0, 2, 2);
        cyc(v_zero, v_nop, "t4_c3");
        status("t4_c4", 1, 0, 0, 0, 2, 3);
        cyc(v_zero, v_f1, "t4_c4");
        status("t4_c5", 1, 0, 0, 0, 2, 3);
        cyc(v_zero, v_dec, "t4_c5");
        do_reset();

        // Watchdog: dut_a traps after 8 stalled FETCH cycles, dut_b keeps waiting.
        opcode = 7'b0000011;
        mem_ready = 1'b0;
        status("t5_start", 0, 0, 0, 0, 0, 0);
        repeat (8) cyc(v_f0, v_f0, "t5_wait");
        status("t5_fired", 0, 0, 1, 0, 0, 0);
        repeat (3) cyc(v_zero, v_f0, "t5_trap");
        status("t5_hold", 0, 0, 1, 0, 0, 0);
        do_reset();

        // 17 LUIs: 4-bit counter wraps to 1, 32-bit counter reads 17.
        mem_ready = 1'b1;
        opcode = 7'b0110111;
        status("t6_start", 0, 0, 0, 0, 0, 0);
        repeat (17) begin
            cyc(v_f1, v_f1, "t6_fetch");
            cyc(v_dec, v_dec, "t6_dec");
            cyc(v_lui, v_lui, "t6_lui");
        end
        status("t6_wrap", 0, 0, 0, 0, 1, 17);
        opcode = 7'b0010111;
        cyc(v_f1, v_f1, "t6_afetch");
        cyc(v_dec, v_dec, "t6_adec");
        cyc(v_auipc, v_auipc, "t6_auipc");

        // Remaining instruction classes with zero-wait memory.
        opcode = 7'b0110011;
        cyc(v_f1, v_f1, "r_fetch");
        cyc(v_dec, v_dec, "r_dec");
        cyc(v_exr, v_exr, "r_exec");
        cyc(v_awb, v_awb, "r_wb");
        opcode = 7'b0010011;
        cyc(v_f1, v_f1, "i_fetch");
        cyc(v_dec, v_dec, "i_dec");
        cyc(v_exi, v_exi, "i_exec");
        cyc(v_awb, v_awb, "i_wb");
        opcode = 7'b1100011;
        cyc(v_f1, v_f1, "b_fetch");
        cyc(v_dec, v_dec, "b_dec");
        cyc(v_br, v_br, "b_branch");
        opcode = 7'b1101111;
        cyc(v_f1, v_f1, "jal_fetch");
        cyc(v_dec, v_dec, "jal_dec");
        cyc(v_jal, v_jal, "jal_jal");
        cyc(v_awb, v_awb, "jal_wb");
        opcode = 7'b1100111;
        cyc(v_f1, v_f1, "jalr_fetch");
        cyc(v_dec, v_dec, "jalr_dec");
        cyc(v_jalr, v_jalr, "jalr_jalr");
        cyc(v_jwb, v_jwb, "jalr_wb");
        status("final", 0, 0, 0, 0, 7, 23);
        cyc(v_f1, v_f1, "final_fetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
